// File: rtl/quad_pkg.sv
// Shared encodings and the transition decoder for the quadrature encoder front end.
package quad_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } quad_state_e;

  // {a,b} channel codes; forward rotation walks Q00 -> Q10 -> Q11 -> Q01 -> Q00.
  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q10 = 2'b10;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q01 = 2'b01;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    DecNone,
    DecUp,
    DecDown,
    DecErr
  } quad_dec_e;

  function automatic quad_dec_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
    quad_dec_e  res;
    logic [1:0] fwd;
    case (prev)
      Q00:     fwd = Q10;
      Q10:     fwd = Q11;
      Q11:     fwd = Q01;
      default: fwd = Q00;
    endcase
    if (prev == cur) begin
      res = DecNone;
    end else if ((prev ^ cur) == 2'b11) begin
      res = DecErr;
    end else if (cur == fwd) begin
      res = DecUp;
    end else begin
      res = DecDown;
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// One encoder channel: two-flop synchroniser followed by a consecutive-cycle debounce filter.
module quad_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic init,
  input  logic din,
  output logic dout
);

  localparam logic [7:0] CntLast = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (init) begin
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      // The Nth consecutive differing sample commits the new level.
      if (cnt_q == CntLast) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature encoder decoder: debounced A/B channels into step pulses, direction,
// a wrapping position count and a sticky illegal-transition flag.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned COUNT_WIDTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   quad_a,
  input  logic                   quad_b,
  input  logic                   clear,
  output logic                   step_enable,
  output logic                   step_direction,
  output logic [COUNT_WIDTH-1:0] position,
  output logic                   quad_error
);

  localparam logic [8:0] InitLast = 9'(DEBOUNCE_CYCLES + 1);

  quad_state_e            state_q, state_d;
  logic [8:0]             init_cnt_q, init_cnt_d;
  logic [1:0]             prev_q, prev_d;
  logic [1:0]             filt;
  logic                   filt_a, filt_b;
  logic                   init;
  logic                   step_q, step_d;
  logic                   dir_q, dir_d;
  logic [COUNT_WIDTH-1:0] pos_q, pos_d;
  logic                   err_q, err_d;

  assign init = (state_q == ST_INIT);
  assign filt = {filt_a, filt_b};

  quad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk (clk),
    .rst (rst),
    .init(init),
    .din (quad_a),
    .dout(filt_a)
  );

  quad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk (clk),
    .rst (rst),
    .init(init),
    .din (quad_b),
    .dout(filt_b)
  );

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = filt;
    step_d     = 1'b0;
    dir_d      = dir_q;
    pos_d      = pos_q;
    err_d      = err_q;
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == InitLast) begin
          state_d = ST_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 9'd1;
        end
      end
      ST_RUN: begin
        case (quad_decode(prev_q, filt))
          DecUp: begin
            step_d = 1'b1;
            dir_d  = DIR_UP;
            pos_d  = pos_q + 1'b1;
          end
          DecDown: begin
            step_d = 1'b1;
            dir_d  = DIR_DOWN;
            pos_d  = pos_q - 1'b1;
          end
          DecErr:  err_d = 1'b1;
          default: ;
        endcase
      end
      default: state_d = ST_INIT;
    endcase
    // A same-cycle step is dropped entirely, direction included.
    if (clear) begin
      step_d = 1'b0;
      dir_d  = dir_q;
      pos_d  = '0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_q     <= Q00;
      step_q     <= 1'b0;
      dir_q      <= DIR_DOWN;
      pos_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      pos_q      <= pos_d;
      err_q      <= err_d;
    end
  end

  assign step_enable    = step_q;
  assign step_direction = dir_q;
  assign position       = pos_q;
  assign quad_error     = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed self-checking bench for quadrature_decoder at DEBOUNCE_CYCLES=4, COUNT_WIDTH=8.
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       quad_a = 1'b0;
  logic       quad_b = 1'b0;
  logic       clear = 1'b0;
  logic       step_enable;
  logic       step_direction;
  logic [7:0] position;
  logic       quad_error;

  int         n_checks = 0;
  int         n_fail = 0;
  int         n_pulses = 0;
  int         pulses_mark;
  logic [7:0] exp_pos = 8'h00;
  logic [1:0] ab = 2'b00;

  quadrature_decoder #(
    .DEBOUNCE_CYCLES(4),
    .COUNT_WIDTH    (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .quad_a        (quad_a),
    .quad_b        (quad_b),
    .clear         (clear),
    .step_enable   (step_enable),
    .step_direction(step_direction),
    .position      (position),
    .quad_error    (quad_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (step_enable) n_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_ab(input logic [1:0] v);
    ab     = v;
    quad_a = v[1];
    quad_b = v[0];
  endtask

  // One legal step, 20 cycles long; detailed mode checks the 7-edge latency and pulse width.
  task automatic do_step(input bit fwd, input bit detailed);
    logic [1:0] nxt;
    if (fwd) nxt = (ab == 2'b00) ? 2'b10 : (ab == 2'b10) ? 2'b11 : (ab == 2'b11) ? 2'b01 : 2'b00;
    else     nxt = (ab == 2'b00) ? 2'b01 : (ab == 2'b01) ? 2'b11 : (ab == 2'b11) ? 2'b10 : 2'b00;
    drive_ab(nxt);
    exp_pos = fwd ? exp_pos + 8'd1 : exp_pos - 8'd1;
    if (detailed) begin
      tick(6);
      check("step_early", step_enable, 0);
      tick(1);
      check("step_at_7", step_enable, 1);
      check("step_dir", step_direction, fwd);
      tick(1);
      check("step_single", step_enable, 0);
      tick(12);
      check("step_pos", position, exp_pos);
    end else begin
      tick(20);
    end
  endtask

  task automatic do_reset(input logic [1:0] v);
    drive_ab(v);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    exp_pos = 8'h00;
  endtask

  initial begin
    // 1: reset while resting at 11, no spurious step or error
    do_reset(2'b11);
    check("rst_step", step_enable, 0);
    check("rst_dir", step_direction, 0);
    check("rst_pos", position, 0);
    check("rst_err", quad_error, 0);
    pulses_mark = n_pulses;
    tick(20);
    check("init11_pulses", n_pulses - pulses_mark, 0);
    check("init11_err", quad_error, 0);
    check("init11_pos", position, 0);

    // 2: four forward steps from 00
    do_reset(2'b00);
    tick(20);
    pulses_mark = n_pulses;
    for (int i = 0; i < 4; i++) do_step(1'b1, 1'b1);
    check("fwd4_pos", position, 8'h04);
    check("fwd4_pulses", n_pulses - pulses_mark, 4);

    // 3: underflow then 256 forward steps back round to FF
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    exp_pos = 8'h00;
    check("clr_pos", position, 0);
    do_step(1'b0, 1'b1);
    check("under_pos", position, 8'hFF);
    check("under_dir", step_direction, 0);
    pulses_mark = n_pulses;
    for (int i = 0; i < 256; i++) do_step(1'b1, 1'b0);
    check("wrap_pos", position, 8'hFF);
    check("wrap_pulses", n_pulses - pulses_mark, 256);

    // 4: glitch rejection on A, starting from 00
    do_step(1'b1, 1'b1);
    check("to00_pos", position, 8'h00);
    pulses_mark = n_pulses;
    quad_a = 1'b1;
    tick(3);
    quad_a = 1'b0;
    tick(20);
    check("glitch3_pulses", n_pulses - pulses_mark, 0);
    check("glitch3_pos", position, 8'h00);
    quad_a = 1'b1;
    tick(4);
    quad_a = 1'b0;
    tick(3);
    check("glitch4_up", step_enable, 1);
    check("glitch4_up_dir", step_direction, 1);
    check("glitch4_up_pos", position, 8'h01);
    tick(20);
    check("glitch4_pulses", n_pulses - pulses_mark, 2);
    check("glitch4_pos", position, 8'h00);
    check("glitch4_dir", step_direction, 0);

    // 5: illegal 00 -> 11, sticky error, then clear
    pulses_mark = n_pulses;
    drive_ab(2'b11);
    tick(20);
    check("err_set", quad_error, 1);
    check("err_pulses", n_pulses - pulses_mark, 0);
    check("err_pos", position, 8'h00);
    do_step(1'b1, 1'b1);
    check("err_sticky", quad_error, 1);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    exp_pos = 8'h00;
    check("err_clr", quad_error, 0);
    check("err_clr_pos", position, 8'h00);

    // 6a: clear collides with a registering step (01 -> 00)
    pulses_mark = n_pulses;
    drive_ab(2'b00);
    tick(6);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    check("clrstep_step", step_enable, 0);
    check("clrstep_pos", position, 8'h00);
    tick(12);
    check("clrstep_pulses", n_pulses - pulses_mark, 0);
    check("clrstep_pos2", position, 8'h00);

    // 6b: reset mid-debounce, then INIT restarts cleanly
    do_step(1'b1, 1'b1);
    check("pre_rst_pos", position, 8'h01);
    drive_ab(2'b00);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_pos = 8'h00;
    check("midrst_step", step_enable, 0);
    check("midrst_dir", step_direction, 0);
    check("midrst_pos", position, 8'h00);
    check("midrst_err", quad_error, 0);
    pulses_mark = n_pulses;
    tick(20);
    check("midrst_pulses", n_pulses - pulses_mark, 0);
    do_step(1'b1, 1'b1);
    check("post_rst_pos", position, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
